// File: rtl/trigger_ctrl_multi.sv
// Multi-source trigger controller: ext comparators, manual and ADC self-trigger.
// Optional TRIG_TIMESTAMP_EN latches a free-running timestamp into trig_time.
`timescale 1ns/1ps
module trigger_ctrl_multi #(
    parameter int N_CH       = 4,
    parameter int DATA_W     = 8,
    parameter int HOLD_W     = 16,
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 16,
    parameter int TS_W       = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        armed,
    input  logic [N_CH-1:0]             ch_enable,
    input  logic [N_CH-1:0]             ext_trig,
    input  logic                        manual_trigger,
    input  logic                        manual_reset,
    input  logic                        auto_reset,
    input  logic [HOLD_W-1:0]           holdoff,
    input  logic                        self_trig_en,
    input  logic [DATA_W-1:0]           self_trig_level,
    input  logic [DATA_W-1:0]           sample,
    input  logic                        sample_valid,
    output logic                        triggered_out,
    output logic                        trig_pulse,
    output logic [$clog2(N_CH+2)-1:0]   trig_src,
    output logic                        comp_reset,
    output logic [CNT_W-1:0]            trig_count,
    output logic [TS_W-1:0]             trig_time,
    output logic                        busy
);
    localparam int SRC_W = $clog2(N_CH + 2);
    localparam int RC_W  = $clog2(RST_CYCLES + 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, ARMED, TRIGD, COMP_RST, HOLDOFF
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] prev;
    logic [RC_W-1:0]   rst_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    logic [N_CH-1:0]   ext_hit;
    logic              ext_any;
    logic [SRC_W-1:0]  ext_idx;
    logic              self_hit;
    logic              accept;
    logic [SRC_W-1:0]  win_src;
    logic              hold_done;

    assign ext_hit  = ext_trig & ch_enable;
    assign ext_any  = |ext_hit;
    assign self_hit = self_trig_en & sample_valid &
                      (sample >= self_trig_level) &
                      (prev < self_trig_level);

    // Scan downwards so the lowest enabled index wins.
    always_comb begin
        ext_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ext_hit[i]) ext_idx = SRC_W'(i);
        end
    end

    always_comb begin
        accept  = 1'b0;
        win_src = '0;
        if (state == IDLE) begin
            if (manual_trigger) begin
                accept  = 1'b1;
                win_src = SRC_W'(N_CH);
            end
        end else if (state == ARMED) begin
            if (ext_any) begin
                accept  = 1'b1;
                win_src = ext_idx;
            end else if (manual_trigger) begin
                accept  = 1'b1;
                win_src = SRC_W'(N_CH);
            end else if (self_hit) begin
                accept  = 1'b1;
                win_src = SRC_W'(N_CH + 1);
            end
        end
    end

    // HOLDOFF lasts max(holdoff,1) cycles; widened to avoid wrap at all-ones.
    assign hold_done = ({1'b0, hold_cnt} + (HOLD_W+1)'(1)) >= {1'b0, holdoff};

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            prev          <= '0;
            rst_cnt       <= '0;
            hold_cnt      <= '0;
            triggered_out <= 1'b0;
            trig_pulse    <= 1'b0;
            trig_src      <= '0;
            comp_reset    <= 1'b0;
            trig_count    <= '0;
            busy          <= 1'b0;
        end else begin
            trig_pulse <= 1'b0;
            if (sample_valid) prev <= sample;
            if (accept) begin
                state         <= TRIGD;
                triggered_out <= 1'b1;
                trig_pulse    <= 1'b1;
                trig_src      <= win_src;
                busy          <= 1'b1;
                if (trig_count != '1) trig_count <= trig_count + CNT_W'(1);
            end else begin
                unique case (state)
                    IDLE: if (armed) state <= ARMED;
                    ARMED: if (!armed) state <= IDLE;
                    TRIGD: begin
                        if (manual_reset || auto_reset) begin
                            state         <= COMP_RST;
                            triggered_out <= 1'b0;
                            comp_reset    <= 1'b1;
                            rst_cnt       <= '0;
                        end
                    end
                    COMP_RST: begin
                        if (rst_cnt == RC_LAST) begin
                            comp_reset <= 1'b0;
                            hold_cnt   <= '0;
                            state      <= HOLDOFF;
                        end else begin
                            rst_cnt <= rst_cnt + RC_W'(1);
                        end
                    end
                    HOLDOFF: begin
                        if (hold_done) begin
                            state <= armed ? ARMED : IDLE;
                            busy  <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef TRIG_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt    <= '0;
            trig_time <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (accept) trig_time <= ts_cnt;
        end
    end
`else
    assign trig_time = '0;
`endif

endmodule

// File: tb/tb_trigger_ctrl_multi.sv
// Scoreboard bench for trigger_ctrl_multi: queued expectations checked on trig_pulse.
`timescale 1ns/1ps
module tb_trigger_ctrl_multi;
    logic        clk = 1'b0;
    logic        reset;
    logic        armed;
    logic [3:0]  ch_enable;
    logic [3:0]  ext_trig;
    logic        manual_trigger;
    logic        manual_reset;
    logic        auto_reset;
    logic [15:0] holdoff;
    logic        self_trig_en;
    logic [7:0]  self_trig_level;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        triggered_out;
    logic        trig_pulse;
    logic [2:0]  trig_src;
    logic        comp_reset;
    logic [15:0] trig_count;
    logic [31:0] trig_time;
    logic        busy;

    typedef struct {
        logic [2:0]  src;
        logic [15:0] cnt;
        logic [31:0] tm;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          fails = 0;
    int unsigned tb_ts = 0;

    trigger_ctrl_multi dut (
        .clk(clk), .reset(reset), .armed(armed),
        .ch_enable(ch_enable), .ext_trig(ext_trig),
        .manual_trigger(manual_trigger), .manual_reset(manual_reset),
        .auto_reset(auto_reset), .holdoff(holdoff),
        .self_trig_en(self_trig_en), .self_trig_level(self_trig_level),
        .sample(sample), .sample_valid(sample_valid),
        .triggered_out(triggered_out), .trig_pulse(trig_pulse),
        .trig_src(trig_src), .comp_reset(comp_reset),
        .trig_count(trig_count), .trig_time(trig_time), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference timestamp: cycles since the last synchronous reset.
    always @(posedge clk) begin
        if (reset) tb_ts <= 0;
        else tb_ts <= tb_ts + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic expect_trig(input logic [2:0] s, input logic [15:0] c);
        exp_t x;
        x.src = s;
        x.cnt = c;
`ifdef TRIG_TIMESTAMP_EN
        x.tm = tb_ts;
`else
        x.tm = 32'd0;
`endif
        sb.push_back(x);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && trig_pulse === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse src=%0d cnt=%0d want=none",
                             trig_src, trig_count);
                end else begin
                    e = sb.pop_front();
                    if (trig_src !== e.src || trig_count !== e.cnt ||
                        trig_time !== e.tm || triggered_out !== 1'b1) begin
                        fails++;
                        $display("FAIL trig_event got src=%0d cnt=%0d tm=%0d trg=%b want src=%0d cnt=%0d tm=%0d trg=1",
                                 trig_src, trig_count, trig_time, triggered_out,
                                 e.src, e.cnt, e.tm);
                    end
                end
            end
        end
    endtask

    task automatic run_rearm(output int n, output int m);
        n = 0;
        while (comp_reset === 1'b1 && n < 20) begin
            n++;
            step();
        end
        m = 0;
        while (busy === 1'b1 && m < 50) begin
            m++;
            step();
        end
    endtask

    initial begin
        int n;
        int m;
        reset = 1'b1; armed = 1'b0; ch_enable = 4'b0;
        ext_trig = 4'b0; manual_trigger = 1'b0; manual_reset = 1'b0;
        auto_reset = 1'b0; holdoff = 16'd0; self_trig_en = 1'b0;
        self_trig_level = 8'h00; sample = 8'h00; sample_valid = 1'b0;
        fork
            monitor();
        join_none
        step();
        step();
        chk("rst_triggered", {31'd0, triggered_out}, 32'd0);
        chk("rst_pulse", {31'd0, trig_pulse}, 32'd0);
        chk("rst_comp_reset", {31'd0, comp_reset}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {16'd0, trig_count}, 32'd0);
        chk("rst_src", {29'd0, trig_src}, 32'd0);
        chk("rst_time", trig_time, 32'd0);
        reset = 1'b0;

        // Lowest enabled ext channel wins (ch1 masked, ch2 enabled).
        ch_enable = 4'b0101;
        armed = 1'b1;
        step();
        ext_trig = 4'b0110;
        expect_trig(3'd2, 16'd1);
        step();
        ext_trig = 4'b0;
        chk("ext_triggered", {31'd0, triggered_out}, 32'd1);
        chk("ext_busy", {31'd0, busy}, 32'd1);
        step();
        chk("pulse_one_cycle", {31'd0, trig_pulse}, 32'd0);

        // Inputs ignored while TRIGGERED.
        ext_trig = 4'b0001;
        manual_trigger = 1'b1;
        step();
        ext_trig = 4'b0;
        manual_trigger = 1'b0;
        chk("trigd_ignore_count", {16'd0, trig_count}, 32'd1);

        // Auto re-arm with holdoff=10, ext held high through holdoff.
        auto_reset = 1'b1;
        holdoff = 16'd10;
        step();
        auto_reset = 1'b0;
        chk("comprst_trig_low", {31'd0, triggered_out}, 32'd0);
        ext_trig = 4'b0001;
        run_rearm(n, m);
        chk("comp_reset_len", n, 32'd4);
        chk("holdoff_len", m, 32'd10);
        manual_trigger = 1'b1;
        expect_trig(3'd0, 16'd2);
        step();
        ext_trig = 4'b0;
        manual_trigger = 1'b0;
        chk("ext_manual_count", {16'd0, trig_count}, 32'd2);

        // Manual re-arm with armed low returns to IDLE.
        armed = 1'b0;
        holdoff = 16'd0;
        manual_reset = 1'b1;
        step();
        manual_reset = 1'b0;
        run_rearm(n, m);
        chk("holdoff0_len", m, 32'd1);
        ext_trig = 4'b0001;
        step();
        ext_trig = 4'b0;
        step();
        chk("idle_not_busy", {31'd0, busy}, 32'd0);
        manual_trigger = 1'b1;
        expect_trig(3'd4, 16'd3);
        step();
        manual_trigger = 1'b0;
        chk("manual_triggered", {31'd0, triggered_out}, 32'd1);

        // Self-trigger on rising crossing of level 0x80.
        armed = 1'b1;
        self_trig_en = 1'b1;
        self_trig_level = 8'h80;
        manual_reset = 1'b1;
        step();
        manual_reset = 1'b0;
        run_rearm(n, m);
        sample_valid = 1'b1;
        sample = 8'h7F;
        step();
        sample = 8'h80;
        expect_trig(3'd5, 16'd4);
        step();
        sample = 8'h90;
        step();
        manual_reset = 1'b1;
        step();
        manual_reset = 1'b0;
        run_rearm(n, m);
        repeat (5) step();
        sample_valid = 1'b0;
        chk("self_no_retrig_count", {16'd0, trig_count}, 32'd4);
        chk("self_no_retrig_trg", {31'd0, triggered_out}, 32'd0);

        // Reset during COMP_RST.
        manual_trigger = 1'b1;
        expect_trig(3'd4, 16'd5);
        step();
        manual_trigger = 1'b0;
        manual_reset = 1'b1;
        step();
        manual_reset = 1'b0;
        step();
        chk("mid_comp_reset", {31'd0, comp_reset}, 32'd1);
        reset = 1'b1;
        armed = 1'b0;
        step();
        reset = 1'b0;
        chk("rst2_comp_reset", {31'd0, comp_reset}, 32'd0);
        chk("rst2_count", {16'd0, trig_count}, 32'd0);
        chk("rst2_busy", {31'd0, busy}, 32'd0);
        chk("rst2_triggered", {31'd0, triggered_out}, 32'd0);
        ext_trig = 4'b0001;
        step();
        ext_trig = 4'b0;
        armed = 1'b1;
        step();
        ext_trig = 4'b0100;
        expect_trig(3'd2, 16'd1);
        step();
        ext_trig = 4'b0;
        repeat (3) step();

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
